// File: rtl/regfile_dump_reader.sv
// Streams FIRST_REG..LAST_REG of the register file over valid/ready, one snapshot per word.
// Define REGDUMP_CHECKSUM_EN to add the XOR checksum output. start is registered once before the FSM acts on it.
module regfile_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_idx,
`ifdef REGDUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              out_last
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [4:0] r_idx;
  logic       r_start;
  logic       w_accept;
  logic       w_start_go;
  logic       w_is_last;

  assign rd_addr    = r_idx;
  assign w_accept   = out_valid & out_ready;
  assign w_start_go = (r_state == S_IDLE) & r_start;
  assign w_is_last  = (r_idx == LAST_IDX);

  // start request stage; pulses outside IDLE never reach the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
    end else begin
      r_start <= start & (r_state == S_IDLE) & ~r_start;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= FIRST_IDX;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 5'd0;
      out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (w_start_go) begin
            r_state <= S_FETCH;
            r_idx   <= FIRST_IDX;
            busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          out_data  <= rd_data;
          out_idx   <= r_idx;
          out_last  <= w_is_last;
          out_valid <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          // payload registers hold until the handshake completes
          if (w_accept) begin
            out_valid <= 1'b0;
            if (w_is_last) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 5'd1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_idx   <= FIRST_IDX;
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_idx     <= FIRST_IDX;
          busy      <= 1'b0;
          done      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  assign checksum = r_checksum;

  // XOR of every accepted word since the last accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_start_go) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum ^ out_data;
    end else begin
      r_checksum <= r_checksum;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: full dump, back-pressure with snapshot check, ignored restarts,
// mid-dump reset, and a single-register instance (checksum checked with REGDUMP_CHECKSUM_EN).
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] regs [32];
  int          total = 0;
  int          bad   = 0;

  logic        a_start, a_busy, a_done, a_out_valid, a_out_ready, a_out_last;
  logic [4:0]  a_rd_addr, a_out_idx;
  logic [31:0] a_rd_data, a_out_data;

  logic        b_start, b_busy, b_done, b_out_valid, b_out_ready, b_out_last;
  logic [4:0]  b_rd_addr, b_out_idx;
  logic [31:0] b_rd_data, b_out_data;
`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] a_checksum, b_checksum;
`endif

  assign a_rd_data = regs[a_rd_addr];
  assign b_rd_data = regs[b_rd_addr];

  always #5 clk = ~clk;

  regfile_dump_reader u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_idx(a_out_idx),
`ifdef REGDUMP_CHECKSUM_EN
    .checksum(a_checksum),
`endif
    .out_last(a_out_last)
  );

  regfile_dump_reader #(.DATA_W(32), .FIRST_REG(5), .LAST_REG(5)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_idx(b_out_idx),
`ifdef REGDUMP_CHECKSUM_EN
    .checksum(b_checksum),
`endif
    .out_last(b_out_last)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full dump on instance A; expected word j is j*0x11111111.
  task automatic dump(input int stall_idx, input bit repulse, input int exp_done);
    int nw, ndone, done_at, first_at, stall;
    nw = 0; ndone = 0; done_at = -1; first_at = -1; stall = 0;
    a_out_ready = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick;
      a_start     = 1'b0;
      a_out_ready = 1'b1;
      chk("busy_done_excl", {31'd0, a_busy & a_done}, 32'd0);
      if (a_done) begin
        ndone++;
        done_at = k;
        if (repulse) a_start = 1'b1;
      end
      if (a_out_valid) begin
        if (first_at < 0) first_at = k;
        if (int'(a_out_idx) == stall_idx && stall < 5) begin
          if (stall == 0) begin
            regs[stall_idx] = 32'hDEADBEEF;
          end else begin
            chk("stall_data", a_out_data, 32'(stall_idx) * 32'h11111111);
            chk("stall_idx", {27'd0, a_out_idx}, 32'(stall_idx));
          end
          stall++;
          a_out_ready = 1'b0;
        end else begin
          chk("word_data", a_out_data, 32'(nw) * 32'h11111111);
          chk("word_idx", {27'd0, a_out_idx}, 32'(nw));
          chk("word_last", {31'd0, a_out_last}, {31'd0, nw == 31});
          nw++;
        end
        if (repulse && a_out_idx == 5'd10) a_start = 1'b1;
      end
    end
    chk("word_count", 32'(nw), 32'd32);
    chk("done_count", 32'(ndone), 32'd1);
    chk("first_valid_lat", 32'(first_at), 32'd2);
    chk("done_lat", 32'(done_at), 32'(exp_done));
    chk("idle_after", {30'd0, a_busy, a_out_valid}, 32'd0);
    if (stall_idx >= 0) regs[stall_idx] = 32'(stall_idx) * 32'h11111111;
  endtask

  initial begin
    bit found;
    int b_done_at;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_out_ready = 1'b0; b_out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;

    // quiet after reset
    chk("rst_out_data", a_out_data, 32'd0);
    chk("rst_out_idx", {27'd0, a_out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, a_out_last}, 32'd0);
    chk("b_rst_rd_addr", {27'd0, b_rd_addr}, 32'd5);
`ifdef REGDUMP_CHECKSUM_EN
    chk("b_rst_checksum", b_checksum, 32'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      chk("idle_busy", {31'd0, a_busy}, 32'd0);
      chk("idle_valid", {31'd0, a_out_valid}, 32'd0);
      chk("idle_done", {31'd0, a_done}, 32'd0);
      chk("idle_rd_addr", {27'd0, a_rd_addr}, 32'd0);
      tick;
    end

    dump(-1, 1'b0, 65);
    dump(3, 1'b0, 70);
    dump(-1, 1'b1, 65);

    // reset while word 7 is being offered
    found = 1'b0;
    a_out_ready = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick;
      if (a_out_valid && a_out_idx == 5'd7) found = 1'b1;
    end
    chk("found_idx7", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_mid_rd_addr", {27'd0, a_rd_addr}, 32'd0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rst_no_done", {30'd0, a_done, a_out_valid}, 32'd0);
    end
    dump(-1, 1'b0, 65);

    // single-register instance
    regs[5] = 32'hA5A5A5A5;
    b_done_at = -1;
    b_out_ready = 1'b1;
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (b_out_valid) begin
        chk("b_data", b_out_data, 32'hA5A5A5A5);
        chk("b_idx", {27'd0, b_out_idx}, 32'd5);
        chk("b_last", {31'd0, b_out_last}, 32'd1);
      end
      if (b_done) begin
        b_done_at = k;
`ifdef REGDUMP_CHECKSUM_EN
        chk("b_checksum", b_checksum, 32'hA5A5A5A5);
`endif
      end
    end
    chk("b_done_lat", 32'(b_done_at), 32'd3);
    chk("b_rd_addr_end", {27'd0, b_rd_addr}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
